router_input_buffer: RTL and testbench



---
 rtl/noc_pkg.sv | 31 +++
 rtl/axis_sync_fifo.sv | 77 +++++++
 rtl/router_input_buffer.sv | 131 +++++++++++++
 tb/tb_router_input_buffer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared mesh-NoC definitions: output directions, input-buffer FSM states and
// coordinate width helpers used by the router input stage, router and mesh top.
package noc_pkg;

    typedef enum logic [2:0] {
        DIR_HOME  = 3'd0,
        DIR_NORTH = 3'd1,
        DIR_EAST  = 3'd2,
        DIR_SOUTH = 3'd3,
        DIR_WEST  = 3'd4
    } dir_e;

    typedef enum logic {
        IB_IDLE   = 1'b0,
        IB_LOCKED = 1'b1
    } ibuf_state_e;

    // A one-wide mesh still needs a 1-bit coordinate field.
    function automatic int coord_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int xw(input int max_routers_x);
        return coord_width(max_routers_x);
    endfunction

    function automatic int yw(input int max_routers_y);
        return coord_width(max_routers_y);
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Generic single-clock FIFO carrying AXI-Stream DATA, DEST and LAST side by side.
// Writes are ignored when full and reads when empty; no full-bypass path.
module axis_sync_fifo #(
    parameter int DATA_WIDTH = 40,
    parameter int DEST_WIDTH = 4,
    parameter int DEPTH      = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          wr_en_i,
    input  logic [DATA_WIDTH-1:0]         wr_data_i,
    input  logic [DEST_WIDTH-1:0]         wr_dest_i,
    input  logic                          wr_last_i,
    input  logic                          rd_en_i,
    output logic [DATA_WIDTH-1:0]         rd_data_o,
    output logic [DEST_WIDTH-1:0]         rd_dest_o,
    output logic                          rd_last_o,
    output logic                          full_o,
    output logic                          empty_o,
    output logic [$clog2(DEPTH+1)-1:0]    count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [DATA_WIDTH-1:0] data_mem_q [DEPTH];
    logic [DEST_WIDTH-1:0] dest_mem_q [DEPTH];
    logic                  last_mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    logic push;
    logic pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign push = wr_en_i && !full_o;
    assign pop  = rd_en_i && !empty_o;

    assign rd_data_o = data_mem_q[rd_ptr_q];
    assign rd_dest_o = dest_mem_q[rd_ptr_q];
    assign rd_last_o = last_mem_q[rd_ptr_q];

    // Storage carries no reset; only pointers and count define what is valid.
    always_ff @(posedge clk_i) begin
        if (push) begin
            data_mem_q[wr_ptr_q] <= wr_data_i;
            dest_mem_q[wr_ptr_q] <= wr_dest_i;
            last_mem_q[wr_ptr_q] <= wr_last_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/router_input_buffer.sv
// Per-port router input stage: buffers incoming flits, computes the XY route from
// the head flit and holds it until that packet's TLAST flit has been forwarded.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   IB_IDLE   | no packet in flight; route computed once a head flit is queued
//   IB_LOCKED | route_o frozen; flits forwarded until the TLAST pop
module router_input_buffer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH    = 40,
    parameter int DEPTH         = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int MAX_ROUTERS_X = 3,
    parameter int MAX_ROUTERS_Y = 3,
    parameter int DEST_WIDTH    = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [DATA_WIDTH-1:0]         s_tdata_i,
    input  logic [DEST_WIDTH-1:0]         s_tdest_i,
    input  logic                          s_tlast_i,
    input  logic                          s_tvalid_i,
    output logic                          s_tready_o,
    output logic [DATA_WIDTH-1:0]         m_tdata_o,
    output logic [DEST_WIDTH-1:0]         m_tdest_o,
    output logic                          m_tlast_o,
    output logic                          m_tvalid_o,
    input  logic                          m_tready_i,
    output logic [2:0]                    route_o,
    output logic                          route_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy_o,
    output logic [15:0]                   pkt_cnt_o
);

    localparam int XW = xw(MAX_ROUTERS_X);
    localparam int YW = yw(MAX_ROUTERS_Y);
    localparam logic [XW-1:0] RX = XW'(ROUTER_X);
    localparam logic [YW-1:0] RY = YW'(ROUTER_Y);

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    logic [XW-1:0] head_x;
    logic [YW-1:0] head_y;
    dir_e          route_d;

    ibuf_state_e   state_q;
    dir_e          route_q;
    logic          route_valid_q;
    logic [15:0]   pkt_cnt_q;

    assign s_tready_o = !fifo_full;
    assign push       = s_tvalid_i && s_tready_o;
    assign m_tvalid_o = (state_q == IB_LOCKED) && !fifo_empty;
    assign pop        = m_tvalid_o && m_tready_i;

    axis_sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEST_WIDTH (DEST_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_en_i    (push),
        .wr_data_i  (s_tdata_i),
        .wr_dest_i  (s_tdest_i),
        .wr_last_i  (s_tlast_i),
        .rd_en_i    (pop),
        .rd_data_o  (m_tdata_o),
        .rd_dest_o  (m_tdest_o),
        .rd_last_o  (m_tlast_o),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (occupancy_o)
    );

    assign head_x = m_tdest_o[XW-1:0];
    assign head_y = m_tdest_o[XW+YW-1:XW];

    // Dimension-order routing: resolve X first, then Y.
    always_comb begin
        route_d = DIR_HOME;
        if (head_x > RX) begin
            route_d = DIR_EAST;
        end else if (head_x < RX) begin
            route_d = DIR_WEST;
        end else if (head_y > RY) begin
            route_d = DIR_SOUTH;
        end else if (head_y < RY) begin
            route_d = DIR_NORTH;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IB_IDLE;
            route_q       <= DIR_HOME;
            route_valid_q <= 1'b0;
            pkt_cnt_q     <= '0;
        end else begin
            case (state_q)
                IB_IDLE: begin
                    if (!fifo_empty) begin
                        route_q       <= route_d;
                        route_valid_q <= 1'b1;
                        state_q       <= IB_LOCKED;
                    end
                end
                IB_LOCKED: begin
                    if (pop && m_tlast_o) begin
                        route_valid_q <= 1'b0;
                        pkt_cnt_q     <= pkt_cnt_q + 16'd1;
                        state_q       <= IB_IDLE;
                    end
                end
                default: begin
                    state_q <= IB_IDLE;
                end
            endcase
        end
    end

    assign route_o       = route_q;
    assign route_valid_o = route_valid_q;
    assign pkt_cnt_o     = pkt_cnt_q;

endmodule

// File: tb/tb_router_input_buffer.sv
// Directed bench for router_input_buffer at router (1,1) of a 3x3 mesh.
module tb_router_input_buffer;
    import noc_pkg::*;

    localparam int DW = 40;
    localparam int DEPTH = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] s_tdata_i;
    logic [3:0]    s_tdest_i;
    logic          s_tlast_i;
    logic          s_tvalid_i;
    logic          s_tready_o;
    logic [DW-1:0] m_tdata_o;
    logic [3:0]    m_tdest_o;
    logic          m_tlast_o;
    logic          m_tvalid_o;
    logic          m_tready_i;
    logic [2:0]    route_o;
    logic          route_valid_o;
    logic [2:0]    occupancy_o;
    logic [15:0]   pkt_cnt_o;

    int n_checks = 0;
    int n_errors = 0;

    router_input_buffer #(
        .DATA_WIDTH    (DW),
        .DEPTH         (DEPTH),
        .ROUTER_X      (1),
        .ROUTER_Y      (1),
        .MAX_ROUTERS_X (3),
        .MAX_ROUTERS_Y (3),
        .DEST_WIDTH    (4)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .s_tdata_i     (s_tdata_i),
        .s_tdest_i     (s_tdest_i),
        .s_tlast_i     (s_tlast_i),
        .s_tvalid_i    (s_tvalid_i),
        .s_tready_o    (s_tready_o),
        .m_tdata_o     (m_tdata_o),
        .m_tdest_o     (m_tdest_o),
        .m_tlast_o     (m_tlast_o),
        .m_tvalid_o    (m_tvalid_o),
        .m_tready_i    (m_tready_i),
        .route_o       (route_o),
        .route_valid_o (route_valid_o),
        .occupancy_o   (occupancy_o),
        .pkt_cnt_o     (pkt_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [3:0] dst(input int y, input int x);
        logic [1:0] yy;
        logic [1:0] xx;
        yy = y[1:0];
        xx = x[1:0];
        return {yy, xx};
    endfunction

    task automatic drive(input logic [DW-1:0] d, input logic [3:0] t, input logic l);
        s_tdata_i  = d;
        s_tdest_i  = t;
        s_tlast_i  = l;
        s_tvalid_i = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int   ex_x [5] = '{2, 0, 1, 1, 1};
        int   ex_y [5] = '{1, 1, 2, 0, 1};
        dir_e ex_d [5] = '{DIR_EAST, DIR_WEST, DIR_SOUTH, DIR_NORTH, DIR_HOME};
        int   acc;

        rst_i = 1'b1;
        s_tdata_i = '0;
        s_tdest_i = '0;
        s_tlast_i = 1'b0;
        s_tvalid_i = 1'b0;
        m_tready_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        // reset / idle
        check("rst_tready", s_tready_o, 1);
        check("rst_tvalid", m_tvalid_o, 0);
        check("rst_rvalid", route_valid_o, 0);
        check("rst_route", route_o, DIR_HOME);
        check("rst_occ", occupancy_o, 0);
        check("rst_pkt", pkt_cnt_o, 0);
        tick();
        check("idle_tvalid", m_tvalid_o, 0);
        check("idle_rvalid", route_valid_o, 0);

        // XY decisions, single-flit packets
        for (int i = 0; i < 5; i++) begin
            drive(DW'(40'h100 + i), dst(ex_y[i], ex_x[i]), 1'b1);
            tick();
            s_tvalid_i = 1'b0;
            check("xy_occ", occupancy_o, 1);
            check("xy_tvalid_early", m_tvalid_o, 0);
            tick();
            check("xy_tvalid", m_tvalid_o, 1);
            check("xy_rvalid", route_valid_o, 1);
            check("xy_route", route_o, ex_d[i]);
            check("xy_data", m_tdata_o, 40'h100 + i);
            m_tready_i = 1'b1;
            tick();
            m_tready_i = 1'b0;
            check("xy_tvalid_after", m_tvalid_o, 0);
            check("xy_rvalid_after", route_valid_o, 0);
            check("xy_pkt", pkt_cnt_o, i + 1);
        end

        // route lock: head to EAST, later flits carry a WEST destination
        for (int f = 0; f < 4; f++) begin
            drive(DW'(40'h200 + f), (f == 0) ? dst(1, 2) : dst(1, 0), f == 3);
            tick();
        end
        s_tvalid_i = 1'b0;
        check("lock_occ", occupancy_o, 4);
        check("lock_tready", s_tready_o, 0);
        m_tready_i = 1'b1;
        for (int f = 0; f < 4; f++) begin
            check("lock_tvalid", m_tvalid_o, 1);
            check("lock_route", route_o, DIR_EAST);
            check("lock_rvalid", route_valid_o, 1);
            check("lock_data", m_tdata_o, 40'h200 + f);
            check("lock_dest", m_tdest_o, (f == 0) ? dst(1, 2) : dst(1, 0));
            check("lock_last", m_tlast_o, f == 3);
            tick();
        end
        m_tready_i = 1'b0;
        check("lock_rvalid_drop", route_valid_o, 0);
        check("lock_pkt", pkt_cnt_o, 6);
        check("lock_occ_end", occupancy_o, 0);

        // backpressure: 6 offered into a 4-deep FIFO with the crossbar stalled
        acc = 0;
        for (int f = 0; f < 6; f++) begin
            drive(DW'(40'h300 + f), dst(1, 1), f == 3);
            if (s_tready_o) acc++;
            tick();
        end
        s_tvalid_i = 1'b0;
        check("full_accepted", acc, 4);
        check("full_tready", s_tready_o, 0);
        check("full_occ", occupancy_o, 4);
        check("full_tvalid", m_tvalid_o, 1);
        check("full_route", route_o, DIR_HOME);
        check("full_data", m_tdata_o, 40'h300);
        repeat (2) tick();
        check("stall_tvalid", m_tvalid_o, 1);
        check("stall_data", m_tdata_o, 40'h300);
        check("stall_occ", occupancy_o, 4);
        m_tready_i = 1'b1;
        for (int f = 0; f < 4; f++) begin
            check("drain_data", m_tdata_o, 40'h300 + f);
            tick();
            if (f == 0) check("drain_tready", s_tready_o, 1);
        end
        m_tready_i = 1'b0;
        check("drain_pkt", pkt_cnt_o, 7);
        check("drain_occ", occupancy_o, 0);

        // back-to-back 2-flit packets: EAST then NORTH
        m_tready_i = 1'b1;
        drive(DW'(40'h400), dst(1, 2), 1'b0);
        tick();
        drive(DW'(40'h401), dst(1, 2), 1'b1);
        tick();
        check("b2b_a0_tvalid", m_tvalid_o, 1);
        check("b2b_a0_route", route_o, DIR_EAST);
        check("b2b_a0_data", m_tdata_o, 40'h400);
        drive(DW'(40'h410), dst(0, 1), 1'b0);
        tick();
        check("b2b_a1_data", m_tdata_o, 40'h401);
        check("b2b_a1_last", m_tlast_o, 1);
        check("b2b_a1_route", route_o, DIR_EAST);
        drive(DW'(40'h411), dst(0, 1), 1'b1);
        tick();
        s_tvalid_i = 1'b0;
        check("b2b_bubble_tvalid", m_tvalid_o, 0);
        check("b2b_bubble_rvalid", route_valid_o, 0);
        check("b2b_pkt1", pkt_cnt_o, 8);
        check("b2b_occ", occupancy_o, 2);
        tick();
        check("b2b_b0_tvalid", m_tvalid_o, 1);
        check("b2b_b0_route", route_o, DIR_NORTH);
        check("b2b_b0_data", m_tdata_o, 40'h410);
        tick();
        check("b2b_b1_tvalid", m_tvalid_o, 1);
        check("b2b_b1_data", m_tdata_o, 40'h411);
        tick();
        m_tready_i = 1'b0;
        check("b2b_end_tvalid", m_tvalid_o, 0);
        check("b2b_pkt2", pkt_cnt_o, 9);
        check("b2b_end_occ", occupancy_o, 0);

        // reset mid-packet, then a fresh packet to WEST
        drive(DW'(40'h500), dst(2, 1), 1'b0);
        tick();
        drive(DW'(40'h501), dst(2, 1), 1'b0);
        tick();
        s_tvalid_i = 1'b0;
        check("mid_occ", occupancy_o, 2);
        check("mid_rvalid", route_valid_o, 1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mid_rst_occ", occupancy_o, 0);
        check("mid_rst_rvalid", route_valid_o, 0);
        check("mid_rst_tvalid", m_tvalid_o, 0);
        check("mid_rst_tready", s_tready_o, 1);
        check("mid_rst_pkt", pkt_cnt_o, 0);
        drive(DW'(40'h600), dst(1, 0), 1'b1);
        tick();
        s_tvalid_i = 1'b0;
        tick();
        check("post_tvalid", m_tvalid_o, 1);
        check("post_route", route_o, DIR_WEST);
        check("post_data", m_tdata_o, 40'h600);
        m_tready_i = 1'b1;
        tick();
        m_tready_i = 1'b0;
        check("post_pkt", pkt_cnt_o, 1);
        check("post_rvalid", route_valid_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
